pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the MIPS fetch stage. It holds the architectural PC in a register and selects the next PC from these sources, highest priority first: exception, exception return, subroutine return, jump/call, taken branch, sequential. It adds an internal return-address stack (RAS) for call/return prediction. Sits between the control/decode logic and instruction memory, replacing the combinational next-PC adder.

## Interface
- `XLEN`, 32: PC and address width.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `EXC_VECTOR`, 32'h8000_0180: exception handler entry.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC; ignored when `exc` is high.
- `exc`  in  1  take exception: next PC = `EXC_VECTOR`.
- `eret`  in  1  exception return: next PC = `epc`.
- `epc`  in  XLEN  saved exception PC.
- `ret`  in  1  subroutine return (jr $ra).
- `jmp`  in  1  jump: next PC = `jmp_addr`.
- `call`  in  1  qualifies `jmp` as jal: push `pc+4` onto the RAS.
- `jmp_addr`  in  XLEN  jump target; also the return target when the RAS is empty.
- `br_taken`  in  1  taken branch: next PC = `br_addr`.
- `br_addr`  in  XLEN  branch target.
- `pc`  out  XLEN  current PC (registered).
- `pc_plus4`  out  XLEN  `pc + 4`, combinational, modulo 2^XLEN.
- `ras_underflow`  out  1  registered one-cycle pulse: a `ret` was taken with the RAS empty.
- `ras_count`  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.

## Operation
- Next-PC selection, highest priority first:
  - `exc` → `EXC_VECTOR`.
  - else `stall` → `pc` unchanged; all redirect inputs are ignored that cycle. Upstream must hold them until the stall drops.
  - else `eret` → `epc`.
  - else `ret` → RAS top if `ras_count`>0; otherwise `jmp_addr` and `ras_underflow`=1 next cycle.
  - else `jmp` → `jmp_addr`. If `call` is also high, push `pc_plus4`.
  - else `br_taken` → `br_addr`.
  - else `pc_plus4`.
- `call` without `jmp` has no effect.
- RAS is a circular buffer with a top pointer:
  - Push on a full stack overwrites the oldest entry; `ras_count` saturates at `RAS_DEPTH`.
  - Pop decrements `ras_count`; the pointer wraps modulo `RAS_DEPTH`.
- RAS is modified only when the PC actually updates with a `ret` or `jmp&call` selection. It is not modified under stall, exception, or eret.
- `ret` and `jmp&call` in the same cycle: `ret` wins, no push.
- Address arithmetic wraps modulo 2^XLEN; no alignment checking (low two bits pass through).

## Timing
- Reset (`reset`=0, async): `pc`=`RESET_VECTOR`, `ras_count`=0, RAS pointer=0, `ras_underflow`=0. RAS entry contents are don't-care.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. The first update after deassertion is at the first rising edge with `reset`=1.
- Latency: inputs are sampled at the rising edge; the new `pc` is visible one cycle later. `pc_plus4` follows `pc` combinationally.
- `ras_underflow` is high for exactly the cycle following the underflowing `ret`.
- No handshake. `stall` is level-sensitive; every cycle without stall advances or redirects.

## Structure
- `pc_pkg`:
  - `pc_sel_t` enum: `PCSEL_EXC`, `PCSEL_HOLD`, `PCSEL_ERET`, `PCSEL_RET`, `PCSEL_JMP`, `PCSEL_BR`, `PCSEL_SEQ`.
  - Instruction-size constant `INSTR_BYTES`=4.
- Sub-module `pc_ras`:
  - Parameters: `XLEN`, `RAS_DEPTH`.
  - Ports: `push`, `pop`, `push_data`, `top`, `count`, `empty`.
- `pc_unit` contains the priority encoder, PC register and underflow flag.

## Test plan
- Reset release, 3 free cycles → `pc` = 0x0, 0x4, 0x8, 0xC.
- At `pc`=0x10, `jmp`=1, `call`=1, `jmp_addr`=0x400 → `pc`=0x400 and `ras_count`=1. Later, `ret`=1 with `jmp_addr`=0xDEAD → `pc`=0x14, `ras_count`=0, no underflow.
- `ret` with the RAS empty and `jmp_addr`=0x200 → `pc`=0x200, `ras_underflow` pulses for 1 cycle.
- 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40 with `RAS_DEPTH`=4 → `ras_count`=4. Then 5 returns → targets 0x44, 0x34, 0x24, 0x14, then fallback to `jmp_addr` with underflow.
- `stall`=1 with `jmp`=1 → `pc` holds and RAS is unchanged. `stall`=1 with `exc`=1 → `pc`=0x8000_0180.
- `exc`, `eret`, `jmp` and `br_taken` all high → `EXC_VECTOR`. Drop `exc` → `epc`. At `pc`=0xFFFF_FFFC sequential → `pc`=0x0. Assert `reset` mid-cycle → `pc`=`RESET_VECTOR` immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the fetch-stage PC unit
package pc_pkg;

  typedef enum logic [2:0] {
    PCSEL_EXC,
    PCSEL_HOLD,
    PCSEL_ERET,
    PCSEL_RET,
    PCSEL_JMP,
    PCSEL_BR,
    PCSEL_SEQ
  } pc_sel_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Exception outranks stall so a trap can never be swallowed by a held pipe.
  function automatic pc_sel_t pc_select(
    input logic exc,
    input logic stall,
    input logic eret,
    input logic ret,
    input logic jmp,
    input logic br_taken
  );
    pc_sel_t sel;
    if (exc)           sel = PCSEL_EXC;
    else if (stall)    sel = PCSEL_HOLD;
    else if (eret)     sel = PCSEL_ERET;
    else if (ret)      sel = PCSEL_RET;
    else if (jmp)      sel = PCSEL_JMP;
    else if (br_taken) sel = PCSEL_BR;
    else               sel = PCSEL_SEQ;
    return sel;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack, oldest entry lost on overflow
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_data,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   wr_idx;
  logic            full;
  logic            do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(RAS_DEPTH));
  assign do_pop = pop && !empty;
  assign top    = mem[ptr];

  // Push and pop together replace the current top in place.
  assign wr_idx = do_pop ? ptr : ptr + PW'(1);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !do_pop) begin
      ptr <= ptr + PW'(1);
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (do_pop && !push) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - architectural PC register with prioritised next-PC select and RAS
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       exc,
  input  logic                       eret,
  input  logic [XLEN-1:0]            epc,
  input  logic                       ret,
  input  logic                       jmp,
  input  logic                       call,
  input  logic [XLEN-1:0]            jmp_addr,
  input  logic                       br_taken,
  input  logic [XLEN-1:0]            br_addr,
  output logic [XLEN-1:0]            pc,
  output logic [XLEN-1:0]            pc_plus4,
  output logic                       ras_underflow,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  pc_sel_t         sel;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_push;
  logic            ras_pop;
  logic            underflow_d;

  assign pc_plus4 = pc + XLEN'(INSTR_BYTES);
  assign sel      = pc_select(exc, stall, eret, ret, jmp, br_taken);

  // The RAS only moves on the cycles where the PC really takes that path.
  assign ras_push    = (sel == PCSEL_JMP) && call;
  assign ras_pop     = (sel == PCSEL_RET) && !ras_empty;
  assign underflow_d = (sel == PCSEL_RET) && ras_empty;

  always_comb begin
    next_pc = pc_plus4;
    unique case (sel)
      PCSEL_EXC:  next_pc = EXC_VECTOR;
      PCSEL_HOLD: next_pc = pc;
      PCSEL_ERET: next_pc = epc;
      PCSEL_RET:  next_pc = ras_empty ? jmp_addr : ras_top;
      PCSEL_JMP:  next_pc = jmp_addr;
      PCSEL_BR:   next_pc = br_addr;
      default:    next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_VECTOR;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= next_pc;
      ras_underflow <= underflow_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed plus random bench for pc_unit against a queue-based model
module tb_pc_unit;

  localparam logic [31:0] RST_V = 32'h0000_0000;
  localparam logic [31:0] EXC_V = 32'h8000_0180;
  localparam int          DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, exc = 1'b0, eret = 1'b0, ret = 1'b0;
  logic        jmp = 1'b0, call = 1'b0, br_taken = 1'b0;
  logic [31:0] epc = '0, jmp_addr = '0, br_addr = '0;
  logic [31:0] pc, pc_plus4;
  logic        ras_underflow;
  logic [2:0]  ras_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  bit          m_uf;
  logic [31:0] m_ras[$];

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (RST_V),
    .EXC_VECTOR   (EXC_V),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .exc           (exc),
    .eret          (eret),
    .epc           (epc),
    .ret           (ret),
    .jmp           (jmp),
    .call          (call),
    .jmp_addr      (jmp_addr),
    .br_taken      (br_taken),
    .br_addr       (br_addr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_underflow (ras_underflow),
    .ras_count     (ras_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    check({tag, ".cnt"}, 32'(ras_count), 32'(m_ras.size()));
    check({tag, ".uf"}, 32'(ras_underflow), 32'(m_uf));
  endtask

  task automatic set_in(input logic e, input logic s, input logic er, input logic r,
                        input logic j, input logic c, input logic b,
                        input logic [31:0] ep, input logic [31:0] ja, input logic [31:0] ba);
    exc = e; stall = s; eret = er; ret = r; jmp = j; call = c; br_taken = b;
    epc = ep; jmp_addr = ja; br_addr = ba;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic model_reset();
    m_pc = RST_V;
    m_uf = 0;
    m_ras.delete();
  endtask

  // One clock: compute the architectural next state, let the edge pass, compare.
  task automatic cycle(input string tag);
    logic [31:0] npc;
    bit          nuf;
    npc = m_pc;
    nuf = 0;
    if (exc) npc = EXC_V;
    else if (stall) npc = m_pc;
    else if (eret) npc = epc;
    else if (ret) begin
      if (m_ras.size() > 0) npc = m_ras.pop_back();
      else begin
        npc = jmp_addr;
        nuf = 1;
      end
    end else if (jmp) begin
      if (call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      npc = jmp_addr;
    end else if (br_taken) npc = br_addr;
    else npc = m_pc + 32'd4;
    @(posedge clock);
    #1;
    m_pc = npc;
    m_uf = nuf;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    idle();
    #1;
    model_reset();
    check("arst.pc", pc, RST_V);
    check("arst.cnt", 32'(ras_count), 32'd0);
    check("arst.uf", 32'(ras_underflow), 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  logic [31:0] ret_exp[5];

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("rst");
    @(negedge clock);
    reset = 1'b1;

    repeat (3) cycle("seq");
    check("seq.c", pc, 32'h0000_000C);
    cycle("seq");

    set_in(0, 0, 0, 0, 1, 1, 0, '0, 32'h400, '0);
    cycle("call");
    check("call.pc", pc, 32'h400);
    check("call.cnt", 32'(ras_count), 32'd1);
    idle();
    cycle("body");
    set_in(0, 0, 0, 1, 0, 0, 0, '0, 32'hDEAD, '0);
    cycle("ret");
    check("ret.pc", pc, 32'h14);
    check("ret.uf", 32'(ras_underflow), 32'd0);

    set_in(0, 0, 0, 1, 0, 0, 0, '0, 32'h200, '0);
    cycle("uflow");
    check("uflow.pc", pc, 32'h200);
    check("uflow.uf", 32'(ras_underflow), 32'd1);
    idle();
    cycle("uflow_end");
    check("uflow_end.uf", 32'(ras_underflow), 32'd0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 1, 1, 0, '0, (i == 4) ? 32'h100 : 32'((i + 1) * 16), '0);
      cycle("deep_call");
    end
    check("deep.cnt", 32'(ras_count), 32'd4);
    ret_exp = '{32'h44, 32'h34, 32'h24, 32'h14, 32'h300};
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 1, 0, 0, 0, '0, 32'h300, '0);
      cycle("deep_ret");
      check("deep_ret.pc", pc, ret_exp[i]);
    end
    check("deep_ret.uf", 32'(ras_underflow), 32'd1);

    set_in(0, 0, 0, 0, 1, 1, 0, '0, 32'h500, '0);
    cycle("pre_stall");
    set_in(0, 1, 0, 0, 1, 1, 0, '0, 32'h900, '0);
    cycle("stall_jmp");
    check("stall.pc", pc, 32'h500);
    set_in(1, 1, 0, 0, 0, 0, 0, '0, '0, '0);
    cycle("stall_exc");
    check("stall_exc.pc", pc, EXC_V);

    set_in(1, 0, 1, 0, 1, 0, 1, 32'h1234, 32'h888, 32'h999);
    cycle("all_hi");
    check("all_hi.pc", pc, EXC_V);
    set_in(0, 0, 1, 0, 1, 0, 1, 32'h1234, 32'h888, 32'h999);
    cycle("eret");
    check("eret.pc", pc, 32'h1234);

    set_in(0, 0, 0, 0, 1, 0, 0, '0, 32'hFFFF_FFFC, '0);
    cycle("to_top");
    check("top.pc4", pc_plus4, 32'h0);
    idle();
    cycle("wrap");
    check("wrap.pc", pc, 32'h0);

    do_reset();

    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 18,
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 25,
             $urandom, ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom);
      cycle("rand");
      if (n == 300) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
